// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period and high time of a slow, asynchronous signal in units of
// CLK_in cycles. A START_in request arms the meter; it waits for a rising edge
// of the synchronized signal, then counts to the falling edge (high time) and
// to the next rising edge (period). The result is held on a valid/ready
// handshake.
//
// Parameters:
//   CNT_W        width of the cycle counter and of both result buses
//   SYNC_STAGES  depth of the SIG_in synchronizer, legal range 2..4
//
// Ports:
//   CLK_in       clock for all logic
//   RST_n_in     synchronous active-low reset
//   SIG_in       asynchronous signal under measurement
//   START_in     one-cycle measurement request (honoured only in IDLE)
//   READY_in     consumer accepts the held result
//   PERIOD_out   cycles from rising edge to next rising edge
//   HIGH_out     cycles from rising edge to falling edge
//   VALID_out    result held and valid
//   TIMEOUT_out  qualifies VALID_out: the counter saturated
//   OVERRUN_out  (continuous mode only) sticky: an unaccepted result was lost
//   BUSY_out     high whenever the FSM is not in IDLE
//
// Build option:
//   PERIOD_METER_CONT_EN  continuous mode. The closing rise of a measurement
//                         opens the next one, results land in a one-entry
//                         output register, a timeout returns to ARM and the
//                         OVERRUN_out port is added.
// -----------------------------------------------------------------------------
module period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_in,
    input  logic             RST_n_in,
    input  logic             SIG_in,
    input  logic             START_in,
    input  logic             READY_in,
    output logic [CNT_W-1:0] PERIOD_out,
    output logic [CNT_W-1:0] HIGH_out,
    output logic             VALID_out,
    output logic             TIMEOUT_out,
`ifdef PERIOD_METER_CONT_EN
    output logic             OVERRUN_out,
`endif
    output logic             BUSY_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_HOLD
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_high_cap;
    logic                   r_high_seen;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high;
    logic                   r_valid;
    logic                   r_timeout;
`ifdef PERIOD_METER_CONT_EN
    logic                   r_overrun;
`endif

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_cnt_max;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_push;
    logic [CNT_W-1:0]       w_res_period;
    logic [CNT_W-1:0]       w_res_high;
    logic                   w_res_timeout;

    // Synchronizer followed by one history flop. Both edges are derived from
    // the same pair of flops, so rise and fall share the same latency and the
    // measured widths are not skewed.
    always_ff @(posedge CLK_in) begin
        if (!RST_n_in) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], SIG_in};
            r_hist <= w_sync;
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_hist;
    assign w_fall = ~w_sync & r_hist;

    // Saturating counter: all-ones is the timeout condition, never wraps.
    assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});
    assign w_cnt_inc = w_cnt_max ? r_cnt : r_cnt + CNT_W'(1);

    // Result production: a closing rise in MEASURE, or saturation in ARM or
    // MEASURE. A rise takes priority over saturation in the same cycle.
    always_comb begin
        w_push        = 1'b0;
        w_res_period  = {CNT_W{1'b1}};
        w_res_high    = {CNT_W{1'b1}};
        w_res_timeout = 1'b0;
        case (r_state)
            S_ARM: begin
                if (!w_rise && w_cnt_max) begin
                    w_push        = 1'b1;
                    w_res_timeout = 1'b1;
                end
            end
            S_MEASURE: begin
                if (w_rise) begin
                    w_push       = 1'b1;
                    w_res_period = r_cnt;
                    // A pulse too narrow to produce a fall reports zero high time.
                    w_res_high   = r_high_seen ? r_high_cap : '0;
                end else if (w_cnt_max) begin
                    w_push        = 1'b1;
                    w_res_timeout = 1'b1;
                    w_res_high    = r_high_seen ? r_high_cap : {CNT_W{1'b1}};
                end
            end
            default: ;
        endcase
    end

    // FSM together with its registered outputs.
    always_ff @(posedge CLK_in) begin
        if (!RST_n_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_high_cap  <= '0;
            r_high_seen <= 1'b0;
            r_period    <= '0;
            r_high      <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef PERIOD_METER_CONT_EN
            r_overrun   <= 1'b0;
`endif
        end else begin
            // Output register: a new result wins over a handshake in the same
            // cycle; otherwise an accepted result drops VALID and TIMEOUT while
            // the data buses keep their last values.
            if (w_push) begin
                r_period  <= w_res_period;
                r_high    <= w_res_high;
                r_valid   <= 1'b1;
                r_timeout <= w_res_timeout;
`ifdef PERIOD_METER_CONT_EN
                if (r_valid && !READY_in) begin
                    r_overrun <= 1'b1;
                end
`endif
            end else if (r_valid && READY_in) begin
                r_valid   <= 1'b0;
                r_timeout <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (START_in) begin
                        r_state <= S_ARM;
                        r_cnt   <= '0;
                    end
                end
                S_ARM: begin
                    if (w_rise) begin
                        r_state     <= S_MEASURE;
                        r_cnt       <= CNT_W'(1);
                        r_high_seen <= 1'b0;
                    end else if (w_cnt_max) begin
`ifdef PERIOD_METER_CONT_EN
                        r_cnt   <= '0;
`else
                        r_state <= S_HOLD;
`endif
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_MEASURE: begin
                    if (w_rise) begin
`ifdef PERIOD_METER_CONT_EN
                        // The closing edge is also the opening edge of the next one.
                        r_cnt       <= CNT_W'(1);
                        r_high_seen <= 1'b0;
`else
                        r_state     <= S_HOLD;
`endif
                    end else if (w_cnt_max) begin
`ifdef PERIOD_METER_CONT_EN
                        r_state <= S_ARM;
                        r_cnt   <= '0;
`else
                        r_state <= S_HOLD;
`endif
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_fall && !r_high_seen) begin
                            r_high_cap  <= r_cnt;
                            r_high_seen <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // START_in is deliberately not looked at here, including
                    // the handshake cycle.
                    if (r_valid && READY_in) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign PERIOD_out  = r_period;
    assign HIGH_out    = r_high;
    assign VALID_out   = r_valid;
    assign TIMEOUT_out = r_timeout;
`ifdef PERIOD_METER_CONT_EN
    assign OVERRUN_out = r_overrun;
`endif
    assign BUSY_out    = (r_state != S_IDLE);

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b0;
    logic        sig    = 1'b0;
    logic        start  = 1'b0;
    logic        ready  = 1'b0;
    logic [31:0] period;
    logic [31:0] high;
    logic        valid;
    logic        timeout;
    logic        busy;

    logic        sig8   = 1'b0;
    logic        start8 = 1'b0;
    logic        ready8 = 1'b0;
    logic [7:0]  period8;
    logic [7:0]  high8;
    logic        valid8;
    logic        timeout8;
    logic        busy8;
`ifdef PERIOD_METER_CONT_EN
    logic        overrun;
    logic        overrun8;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] period;
        logic [31:0] high;
        logic        timeout;
    } exp_t;
    exp_t sb[$];

    period_meter #(.CNT_W(32), .SYNC_STAGES(2)) u_dut (
        .CLK_in      (clk),
        .RST_n_in    (rst_n),
        .SIG_in      (sig),
        .START_in    (start),
        .READY_in    (ready),
        .PERIOD_out  (period),
        .HIGH_out    (high),
        .VALID_out   (valid),
        .TIMEOUT_out (timeout),
`ifdef PERIOD_METER_CONT_EN
        .OVERRUN_out (overrun),
`endif
        .BUSY_out    (busy)
    );

    period_meter #(.CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
        .CLK_in      (clk),
        .RST_n_in    (rst_n),
        .SIG_in      (sig8),
        .START_in    (start8),
        .READY_in    (ready8),
        .PERIOD_out  (period8),
        .HIGH_out    (high8),
        .VALID_out   (valid8),
        .TIMEOUT_out (timeout8),
`ifdef PERIOD_METER_CONT_EN
        .OVERRUN_out (overrun8),
`endif
        .BUSY_out    (busy8)
    );

    // Periodic test signal: sig_high cycles high out of every sig_period.
    int sig_period = 8;
    int sig_high   = 4;
    bit sig_run    = 1'b0;
    int phase      = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sig_run) begin
                phase = (phase + 1) % sig_period;
                sig   = (phase < sig_high);
            end else begin
                phase = 0;
                sig   = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_sig(input int p, input int h);
        sig_run = 1'b0;
        repeat (2) @(posedge clk);
        sig_period = p;
        sig_high   = h;
        sig_run    = 1'b1;
        repeat (2 * p) @(posedge clk);
    endtask

    // Returns at a falling edge where VALID is high, or with ok=0 on budget.
    task automatic wait_valid(input int budget, input bit use8, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (use8 ? valid8 : valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b1;
        start8 = 1'b1;
        ready  = 1'b1;
        sig_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 sig8 = ~sig8;
            @(negedge clk);
            vectors++;
            if ({period, high, valid, timeout, busy} !== '0) begin
                $display("FAIL reset_hold[%0d]: got p=%0d h=%0d v=%b t=%b b=%b, required all 0",
                         i, period, high, valid, timeout, busy);
                miscompares++;
            end
            vectors++;
            if ({period8, high8, valid8, timeout8, busy8} !== '0) begin
                $display("FAIL reset_hold8[%0d]: got p=%0d h=%0d v=%b t=%b b=%b, required all 0",
                         i, period8, high8, valid8, timeout8, busy8);
                miscompares++;
            end
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        start  = 1'b0;
        start8 = 1'b0;
        sig8   = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({period, high, valid, timeout, busy} !== '0) begin
            $display("FAIL reset_idle: got p=%0d h=%0d v=%b t=%b b=%b, required all 0",
                     period, high, valid, timeout, busy);
            miscompares++;
        end
`ifdef PERIOD_METER_CONT_EN
        vectors++;
        if (overrun !== 1'b0) begin
            $display("FAIL reset_overrun: got %b, required 0", overrun);
            miscompares++;
        end
`endif
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_measure();
        int   pat_p[5] = '{8, 12, 20, 6, 9};
        int   pat_h[5] = '{4, 3, 15, 1, 5};
        exp_t e;
        bit   ok;
        for (int k = 0; k < 5; k++) begin
            set_sig(pat_p[k], pat_h[k]);
            ready = 1'b1;
            @(posedge clk);
            #1 start = 1'b1;
            e.period  = pat_p[k];
            e.high    = pat_h[k];
            e.timeout = 1'b0;
            sb.push_back(e);
            @(posedge clk);
            #1 start = 1'b0;
            wait_valid(3 * pat_p[k] + 30, 1'b0, ok);
            vectors++;
            if (!ok) begin
                $display("FAIL measure_valid[%0d]: VALID never rose, required 1", k);
                miscompares++;
                sb.delete();
            end else begin
                e = sb.pop_front();
                $display("result: period=%0d high=%0d timeout=%b", period, high, timeout);
                vectors++;
                if (period !== e.period || high !== e.high || timeout !== e.timeout) begin
                    $display("FAIL measure[%0d]: got p=%0d h=%0d t=%b, required p=%0d h=%0d t=%b",
                             k, period, high, timeout, e.period, e.high, e.timeout);
                    miscompares++;
                end
                @(negedge clk);
                vectors++;
                if (valid !== 1'b0 || busy !== 1'b0) begin
                    $display("FAIL measure_done[%0d]: got v=%b b=%b, required v=0 b=0",
                             k, valid, busy);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        bit   ok;
        set_sig(64, 16);
        ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        e.period  = 64;
        e.high    = 16;
        e.timeout = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        wait_valid(300, 1'b0, ok);
        vectors++;
        if (!ok) begin
            $display("FAIL hold_valid: VALID never rose, required 1");
            miscompares++;
            sb.delete();
        end else begin
            e = sb.pop_front();
            $display("result: period=%0d high=%0d timeout=%b", period, high, timeout);
            for (int i = 0; i < 20; i++) begin
                vectors++;
                if (period !== e.period || high !== e.high || valid !== 1'b1 || timeout !== 1'b0) begin
                    $display("FAIL hold[%0d]: got p=%0d h=%0d v=%b t=%b, required p=%0d h=%0d v=1 t=0",
                             i, period, high, valid, timeout, e.period, e.high);
                    miscompares++;
                end
                @(posedge clk);
                #1;
                @(negedge clk);
            end
            @(posedge clk);
            #1 ready = 1'b1;
            @(negedge clk);
            vectors++;
            if (valid !== 1'b1) begin
                $display("FAIL hold_last: got v=%b, required 1", valid);
                miscompares++;
            end
            @(posedge clk);
            #1 ready = 1'b0;
            @(negedge clk);
            vectors++;
            if (valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0 || period !== 32'd64 || high !== 32'd16) begin
                $display("FAIL hold_release: got v=%b t=%b b=%b p=%0d h=%0d, required v=0 t=0 b=0 p=64 h=16",
                         valid, timeout, busy, period, high);
                miscompares++;
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        bit   ok;
        int   vcnt = 0;
        int   bcnt = 0;
        set_sig(8, 4);
        ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;   // held high through ARM, MEASURE and the handshake
        e.period  = 8;
        e.high    = 4;
        e.timeout = 1'b0;
        sb.push_back(e);
        wait_valid(60, 1'b0, ok);
        vectors++;
        if (!ok) begin
            $display("FAIL ignore_valid: VALID never rose, required 1");
            miscompares++;
            sb.delete();
        end else begin
            e = sb.pop_front();
            $display("result: period=%0d high=%0d timeout=%b", period, high, timeout);
            vectors++;
            if (period !== e.period || high !== e.high) begin
                $display("FAIL ignore_result: got p=%0d h=%0d, required p=%0d h=%0d",
                         period, high, e.period, e.high);
                miscompares++;
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (busy) bcnt++;
        end
        vectors++;
        if (vcnt != 0 || bcnt != 0) begin
            $display("FAIL ignore_idle: got %0d valid and %0d busy cycles, required 0 and 0", vcnt, bcnt);
            miscompares++;
        end
    endtask

    task automatic test_timeout8();
        bit ok;
        ready8 = 1'b1;
        sig8   = 1'b0;
        @(posedge clk);
        #1 start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_valid(400, 1'b1, ok);
        vectors++;
        if (!ok) begin
            $display("FAIL timeout_arm_valid: VALID never rose, required 1");
            miscompares++;
        end else begin
            $display("result: period=%0d high=%0d timeout=%b", period8, high8, timeout8);
            vectors++;
            if (period8 !== 8'd255 || timeout8 !== 1'b1) begin
                $display("FAIL timeout_arm: got p=%0d t=%b, required p=255 t=1", period8, timeout8);
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if (valid8 !== 1'b0 || timeout8 !== 1'b0 || busy8 !== 1'b0) begin
                $display("FAIL timeout_arm_done: got v=%b t=%b b=%b, required 0 0 0",
                         valid8, timeout8, busy8);
                miscompares++;
            end
        end
        // One 10-cycle pulse, then the signal stays low: saturation in MEASURE.
        @(posedge clk);
        #1 start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 sig8 = 1'b1;
        repeat (10) @(posedge clk);
        #1 sig8 = 1'b0;
        wait_valid(400, 1'b1, ok);
        vectors++;
        if (!ok) begin
            $display("FAIL timeout_meas_valid: VALID never rose, required 1");
            miscompares++;
        end else begin
            $display("result: period=%0d high=%0d timeout=%b", period8, high8, timeout8);
            vectors++;
            if (period8 !== 8'd255 || high8 !== 8'd10 || timeout8 !== 1'b1) begin
                $display("FAIL timeout_meas: got p=%0d h=%0d t=%b, required p=255 h=10 t=1",
                         period8, high8, timeout8);
                miscompares++;
            end
        end
        ready8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_sig(64, 16);
        ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL reset_mid_busy: got %b, required 1", busy);
            miscompares++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({valid, timeout, busy} !== 3'b000) begin
            $display("FAIL reset_mid: got v=%b t=%b b=%b, required 0 0 0", valid, timeout, busy);
            miscompares++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

`ifdef PERIOD_METER_CONT_EN
    task automatic test_cont();
        exp_t e;
        int   last = -1;
        int   got  = 0;
        set_sig(16, 8);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.period  = 16;
            e.high    = 8;
            e.timeout = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            @(negedge clk);
            if (valid) begin
                e = sb.pop_front();
                got++;
                $display("result: period=%0d high=%0d timeout=%b", period, high, timeout);
                vectors++;
                if (period !== e.period || high !== e.high || timeout !== e.timeout) begin
                    $display("FAIL cont[%0d]: got p=%0d h=%0d t=%b, required p=%0d h=%0d t=%b",
                             got, period, high, timeout, e.period, e.high, e.timeout);
                    miscompares++;
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last != 16) begin
                        $display("FAIL cont_spacing[%0d]: got %0d cycles, required 16", got, cyc - last);
                        miscompares++;
                    end
                end
                last = cyc;
            end
        end
        vectors++;
        if (got != 4) begin
            $display("FAIL cont_count: got %0d results, required 4", got);
            miscompares++;
            sb.delete();
        end
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (overrun !== 1'b1 || valid !== 1'b1 || period !== 32'd16) begin
            $display("FAIL cont_overrun: got o=%b v=%b p=%0d, required o=1 v=1 p=16", overrun, valid, period);
            miscompares++;
        end
        @(posedge clk);
        #1 ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (overrun !== 1'b1) begin
            $display("FAIL cont_sticky: got %b, required 1", overrun);
            miscompares++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL cont_reset: got o=%b b=%b, required 0 0", overrun, busy);
            miscompares++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
`ifndef PERIOD_METER_CONT_EN
        test_measure();
        test_hold();
        test_ignore_start();
        test_timeout8();
`endif
        test_reset_mid();
`ifdef PERIOD_METER_CONT_EN
        test_cont();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
